dcmac_rx_2seg: RTL and testbench

//  Receive-side counterpart of the 2-segment DCMAC tx adapter. Takes the DCMAC 2-segment rx

---
 rtl/dcmac_rx_2seg_if.sv | 61 ++++++
 rtl/dcmac_rx_2seg.sv | 184 ++++++++++++++++++
 tb/tb_dcmac_rx_2seg.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dcmac_rx_2seg_if.sv
// Bus bundle for the 2-segment DCMAC rx adapter: the DCMAC rx segments in and four lockstep AXI-S lanes out.
interface dcmac_rx_2seg_if;
  logic         rx_axis_tvalid;
  logic [127:0] rx_axis_tdata0;
  logic [127:0] rx_axis_tdata1;
  logic         rx_axis_tuser_ena0;
  logic         rx_axis_tuser_ena1;
  logic         rx_axis_tuser_sop0;
  logic         rx_axis_tuser_sop1;
  logic         rx_axis_tuser_eop0;
  logic         rx_axis_tuser_eop1;
  logic [3:0]   rx_axis_tuser_mty0;
  logic [3:0]   rx_axis_tuser_mty1;
  logic         rx_axis_tuser_err0;
  logic         rx_axis_tuser_err1;

  logic [127:0] axis0_out_tdata;
  logic [127:0] axis1_out_tdata;
  logic [127:0] axis2_out_tdata;
  logic [127:0] axis3_out_tdata;
  logic [5:0]   axis0_out_tuser;
  logic [5:0]   axis1_out_tuser;
  logic [5:0]   axis2_out_tuser;
  logic [5:0]   axis3_out_tuser;
  logic         axis0_out_tlast;
  logic         axis1_out_tlast;
  logic         axis2_out_tlast;
  logic         axis3_out_tlast;
  logic         axis0_out_tvalid;
  logic         axis1_out_tvalid;
  logic         axis2_out_tvalid;
  logic         axis3_out_tvalid;
  logic         axis0_out_tready;
  logic         axis1_out_tready;
  logic         axis2_out_tready;
  logic         axis3_out_tready;

  modport master (
    output rx_axis_tvalid, rx_axis_tdata0, rx_axis_tdata1,
           rx_axis_tuser_ena0, rx_axis_tuser_ena1, rx_axis_tuser_sop0, rx_axis_tuser_sop1,
           rx_axis_tuser_eop0, rx_axis_tuser_eop1, rx_axis_tuser_mty0, rx_axis_tuser_mty1,
           rx_axis_tuser_err0, rx_axis_tuser_err1,
    input  axis0_out_tdata, axis1_out_tdata, axis2_out_tdata, axis3_out_tdata,
           axis0_out_tuser, axis1_out_tuser, axis2_out_tuser, axis3_out_tuser,
           axis0_out_tlast, axis1_out_tlast, axis2_out_tlast, axis3_out_tlast,
           axis0_out_tvalid, axis1_out_tvalid, axis2_out_tvalid, axis3_out_tvalid,
    output axis0_out_tready, axis1_out_tready, axis2_out_tready, axis3_out_tready
  );

  modport slave (
    input  rx_axis_tvalid, rx_axis_tdata0, rx_axis_tdata1,
           rx_axis_tuser_ena0, rx_axis_tuser_ena1, rx_axis_tuser_sop0, rx_axis_tuser_sop1,
           rx_axis_tuser_eop0, rx_axis_tuser_eop1, rx_axis_tuser_mty0, rx_axis_tuser_mty1,
           rx_axis_tuser_err0, rx_axis_tuser_err1,
    output axis0_out_tdata, axis1_out_tdata, axis2_out_tdata, axis3_out_tdata,
           axis0_out_tuser, axis1_out_tuser, axis2_out_tuser, axis3_out_tuser,
           axis0_out_tlast, axis1_out_tlast, axis2_out_tlast, axis3_out_tlast,
           axis0_out_tvalid, axis1_out_tvalid, axis2_out_tvalid, axis3_out_tvalid,
    input  axis0_out_tready, axis1_out_tready, axis2_out_tready, axis3_out_tready
  );
endinterface

// File: rtl/dcmac_rx_2seg.sv
// Repacks the DCMAC 2-segment rx stream into 4-lane packet-aligned words, buffered by a
// fall-through FIFO; words that cannot be stored are dropped and counted.
module dcmac_rx_2seg #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  dcmac_rx_2seg_if.slave   bus,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PKT  = 1'b1;

  typedef struct packed {
    logic              last;
    logic [3:0][5:0]   user;
    logic [3:0][127:0] data;
  } word_t;

  // n = filled slot count; err/mty land on the last filled slot of a closing word
  function automatic word_t mk_word(input logic [3:0][127:0] d, input logic [2:0] n,
                                    input logic last, input logic err, input logic [3:0] mty);
    word_t      w;
    logic [1:0] ls;
    w  = '0;
    ls = 2'(n - 3'd1);
    w.last = last;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < 32'(n)) w.data[i] = d[i];
      else            w.user[i][4] = 1'b1;
    end
    if (last) begin
      w.user[ls][5]   = err;
      w.user[ls][3:0] = mty;
    end
    return w;
  endfunction

  logic [1:0][127:0] s_d;
  logic [1:0]        s_ena, s_sop, s_eop, s_err;
  logic [1:0][3:0]   s_mty;

  assign s_d   = {bus.rx_axis_tdata1, bus.rx_axis_tdata0};
  assign s_ena = {bus.rx_axis_tuser_ena1, bus.rx_axis_tuser_ena0};
  assign s_sop = {bus.rx_axis_tuser_sop1, bus.rx_axis_tuser_sop0};
  assign s_eop = {bus.rx_axis_tuser_eop1, bus.rx_axis_tuser_eop0};
  assign s_err = {bus.rx_axis_tuser_err1, bus.rx_axis_tuser_err0};
  assign s_mty = {bus.rx_axis_tuser_mty1, bus.rx_axis_tuser_mty0};

  logic [0:0]        st, st_n;
  logic [1:0]        ptr, ptr_n;
  logic [3:0][127:0] slot, slot_n;
  word_t             cw [3];
  logic [1:0]        nc;

  // Walk seg0 then seg1; a single cycle can close up to three words in the worst case
  always_comb begin
    st_n   = st;
    ptr_n  = ptr;
    slot_n = slot;
    nc     = '0;
    cw[0]  = '0;
    cw[1]  = '0;
    cw[2]  = '0;
    if (bus.rx_axis_tvalid) begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (s_ena[s]) begin
          if (s_sop[s] && st_n == PKT) begin
            if (ptr_n != 2'd0) begin
              cw[nc] = mk_word(slot_n, {1'b0, ptr_n}, 1'b1, 1'b1, 4'd0);
              nc     = nc + 2'd1;
            end
            st_n  = IDLE;
            ptr_n = '0;
          end
          if (st_n == PKT || s_sop[s]) begin
            slot_n[ptr_n] = s_d[s];
            if (s_eop[s]) begin
              cw[nc] = mk_word(slot_n, 3'(ptr_n) + 3'd1, 1'b1, s_err[s], s_mty[s]);
              nc     = nc + 2'd1;
              st_n   = IDLE;
              ptr_n  = '0;
            end else begin
              if (ptr_n == 2'd3) begin
                cw[nc] = mk_word(slot_n, 3'd4, 1'b0, 1'b0, 4'd0);
                nc     = nc + 2'd1;
              end
              ptr_n = ptr_n + 2'd1;
              st_n  = PKT;
            end
          end
        end
      end
    end
  end

  word_t      wq, sp, q0, q1;
  logic       wq_v, sp_v, q0v, q1v;
  logic [1:0] sdrop;

  // Pending spill takes the write slot first; only one further word fits behind it
  always_comb begin
    q0 = '0; q1 = '0; q0v = 1'b0; q1v = 1'b0; sdrop = '0;
    if (sp_v) begin
      q0 = sp; q0v = 1'b1;
      if (nc != 2'd0) begin q1 = cw[0]; q1v = 1'b1; end
      if (nc > 2'd1) sdrop = nc - 2'd1;
    end else begin
      if (nc != 2'd0) begin q0 = cw[0]; q0v = 1'b1; end
      if (nc > 2'd1)  begin q1 = cw[1]; q1v = 1'b1; end
      if (nc == 2'd3) sdrop = 2'd1;
    end
  end

  word_t         mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push_ok, fdrop;
  logic [CNT_W:0] cnt_sum;
  word_t         head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && bus.axis0_out_tready;
  assign push_ok = wq_v && (!full || pop);
  assign fdrop   = wq_v && full && !pop;
  assign cnt_sum = {1'b0, drop_count} + (CNT_W+1)'(sdrop) + (CNT_W+1)'(fdrop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      ptr        <= '0;
      slot       <= '0;
      wq         <= '0;
      wq_v       <= 1'b0;
      sp         <= '0;
      sp_v       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      st     <= st_n;
      ptr    <= ptr_n;
      slot   <= slot_n;
      wq     <= q0;
      wq_v   <= q0v;
      sp     <= q1;
      sp_v   <= q1v;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (fdrop)   overflow <= 1'b1;
      drop_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign bus.axis0_out_tdata  = head.data[0];
  assign bus.axis1_out_tdata  = head.data[1];
  assign bus.axis2_out_tdata  = head.data[2];
  assign bus.axis3_out_tdata  = head.data[3];
  assign bus.axis0_out_tuser  = head.user[0];
  assign bus.axis1_out_tuser  = head.user[1];
  assign bus.axis2_out_tuser  = head.user[2];
  assign bus.axis3_out_tuser  = head.user[3];
  assign bus.axis0_out_tlast  = head.last;
  assign bus.axis1_out_tlast  = head.last;
  assign bus.axis2_out_tlast  = head.last;
  assign bus.axis3_out_tlast  = head.last;
  assign bus.axis0_out_tvalid = !empty;
  assign bus.axis1_out_tvalid = !empty;
  assign bus.axis2_out_tvalid = !empty;
  assign bus.axis3_out_tvalid = !empty;

  logic unused_tready;
  assign unused_tready = ^{bus.axis1_out_tready, bus.axis2_out_tready, bus.axis3_out_tready};
endmodule

// File: tb/tb_dcmac_rx_2seg.sv
// Directed bench for dcmac_rx_2seg: packing cases, spill, overflow/drop counting and reset.
module tb_dcmac_rx_2seg;
  logic        clk = 1'b0;
  logic        reset;
  logic        overflow;
  logic [15:0] drop_count;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dcmac_rx_2seg_if bus();

  dcmac_rx_2seg #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [31:0] v;
    v = 32'hA500_0000 + 32'(n);
    return {4{v}};
  endfunction

  task automatic clr_inputs();
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tdata0 = '0; bus.rx_axis_tdata1 = '0;
    bus.rx_axis_tuser_ena0 = 1'b0; bus.rx_axis_tuser_ena1 = 1'b0;
    bus.rx_axis_tuser_sop0 = 1'b0; bus.rx_axis_tuser_sop1 = 1'b0;
    bus.rx_axis_tuser_eop0 = 1'b0; bus.rx_axis_tuser_eop1 = 1'b0;
    bus.rx_axis_tuser_mty0 = '0;   bus.rx_axis_tuser_mty1 = '0;
    bus.rx_axis_tuser_err0 = 1'b0; bus.rx_axis_tuser_err1 = 1'b0;
  endtask

  task automatic set_seg(input int s, input logic sop, input logic eop, input logic [3:0] mty,
                         input logic err, input logic [127:0] d);
    if (s == 0) begin
      bus.rx_axis_tuser_ena0 = 1'b1; bus.rx_axis_tuser_sop0 = sop; bus.rx_axis_tuser_eop0 = eop;
      bus.rx_axis_tuser_mty0 = mty;  bus.rx_axis_tuser_err0 = err; bus.rx_axis_tdata0 = d;
    end else begin
      bus.rx_axis_tuser_ena1 = 1'b1; bus.rx_axis_tuser_sop1 = sop; bus.rx_axis_tuser_eop1 = eop;
      bus.rx_axis_tuser_mty1 = mty;  bus.rx_axis_tuser_err1 = err; bus.rx_axis_tdata1 = d;
    end
  endtask

  task automatic cyc(input logic v);
    bus.rx_axis_tvalid = v;
    @(posedge clk);
    #1;
    clr_inputs();
  endtask

  task automatic check_word(input string tag,
                            input logic [127:0] d0, input logic [127:0] d1,
                            input logic [127:0] d2, input logic [127:0] d3,
                            input logic [5:0] u0, input logic [5:0] u1,
                            input logic [5:0] u2, input logic [5:0] u3, input logic last);
    chk({tag, ".valid0"}, 128'(bus.axis0_out_tvalid), 128'd1);
    chk({tag, ".valid3"}, 128'(bus.axis3_out_tvalid), 128'd1);
    chk({tag, ".data0"}, bus.axis0_out_tdata, d0);
    chk({tag, ".data1"}, bus.axis1_out_tdata, d1);
    chk({tag, ".data2"}, bus.axis2_out_tdata, d2);
    chk({tag, ".data3"}, bus.axis3_out_tdata, d3);
    chk({tag, ".user0"}, 128'(bus.axis0_out_tuser), 128'(u0));
    chk({tag, ".user1"}, 128'(bus.axis1_out_tuser), 128'(u1));
    chk({tag, ".user2"}, 128'(bus.axis2_out_tuser), 128'(u2));
    chk({tag, ".user3"}, 128'(bus.axis3_out_tuser), 128'(u3));
    chk({tag, ".last0"}, 128'(bus.axis0_out_tlast), 128'(last));
    chk({tag, ".last3"}, 128'(bus.axis3_out_tlast), 128'(last));
  endtask

  task automatic pop();
    bus.axis0_out_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.axis0_out_tready = 1'b0;
  endtask

  initial begin
    clr_inputs();
    bus.axis0_out_tready = 1'b0; bus.axis1_out_tready = 1'b0;
    bus.axis2_out_tready = 1'b0; bus.axis3_out_tready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 128'(bus.axis0_out_tvalid), 128'd0);
    chk("rst.data0", bus.axis0_out_tdata, 128'd0);
    chk("rst.user0", 128'(bus.axis0_out_tuser), 128'd0);
    chk("rst.last", 128'(bus.axis0_out_tlast), 128'd0);
    chk("rst.ovf", 128'(overflow), 128'd0);
    chk("rst.drop", 128'(drop_count), 128'd0);
    reset = 1'b0;
    cyc(1'b0);

    // 64B packet, with first-word latency checks
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(1)); set_seg(1, 1'b0, 1'b0, 4'd0, 1'b0, pat(2)); cyc(1'b1);
    set_seg(0, 1'b0, 1'b0, 4'd0, 1'b0, pat(3)); set_seg(1, 1'b0, 1'b1, 4'd0, 1'b0, pat(4)); cyc(1'b1);
    chk("lat.k", 128'(bus.axis0_out_tvalid), 128'd0);
    cyc(1'b0);
    chk("lat.k1", 128'(bus.axis0_out_tvalid), 128'd1);

    // 40B packet, with ignored segments while rx_axis_tvalid=0 in between
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(5)); set_seg(1, 1'b0, 1'b0, 4'd0, 1'b0, pat(6)); cyc(1'b1);
    set_seg(0, 1'b0, 1'b1, 4'd0, 1'b0, pat(99)); set_seg(1, 1'b1, 1'b1, 4'd0, 1'b0, pat(98)); cyc(1'b0);
    set_seg(0, 1'b0, 1'b1, 4'd8, 1'b0, pat(7)); cyc(1'b1);

    // eop in seg0 and sop in seg1 of the same cycle
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(8)); set_seg(1, 1'b0, 1'b0, 4'd0, 1'b0, pat(9)); cyc(1'b1);
    set_seg(0, 1'b0, 1'b1, 4'd3, 1'b0, pat(10)); set_seg(1, 1'b1, 1'b0, 4'd0, 1'b0, pat(11)); cyc(1'b1);
    set_seg(0, 1'b0, 1'b1, 4'd0, 1'b0, pat(12)); cyc(1'b1);

    // sop inside an open packet; two words close in one cycle
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(13)); set_seg(1, 1'b0, 1'b0, 4'd0, 1'b0, pat(14)); cyc(1'b1);
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(15)); set_seg(1, 1'b0, 1'b1, 4'd2, 1'b0, pat(16)); cyc(1'b1);
    repeat (3) cyc(1'b0);

    check_word("w1", pat(1), pat(2), pat(3), pat(4), 6'h00, 6'h00, 6'h00, 6'h00, 1'b1);
    cyc(1'b0);
    chk("w1.stall", bus.axis0_out_tdata, pat(1));
    pop();
    check_word("w2", pat(5), pat(6), pat(7), 128'd0, 6'h00, 6'h00, 6'h08, 6'h10, 1'b1);
    pop();
    check_word("w3", pat(8), pat(9), pat(10), 128'd0, 6'h00, 6'h00, 6'h03, 6'h10, 1'b1);
    pop();
    check_word("w4", pat(11), pat(12), 128'd0, 128'd0, 6'h00, 6'h00, 6'h10, 6'h10, 1'b1);
    pop();
    check_word("w5", pat(13), pat(14), 128'd0, 128'd0, 6'h00, 6'h20, 6'h10, 6'h10, 1'b1);
    pop();
    check_word("w6", pat(15), pat(16), 128'd0, 128'd0, 6'h00, 6'h02, 6'h10, 6'h10, 1'b1);
    pop();
    chk("drain1.valid", 128'(bus.axis0_out_tvalid), 128'd0);

    // FIFO_DEPTH+3 words while stalled
    for (int i = 0; i < 19; i++) begin
      set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(100 + 4*i));
      set_seg(1, 1'b0, 1'b0, 4'd0, 1'b0, pat(101 + 4*i)); cyc(1'b1);
      set_seg(0, 1'b0, 1'b0, 4'd0, 1'b0, pat(102 + 4*i));
      set_seg(1, 1'b0, 1'b1, 4'd0, 1'b0, pat(103 + 4*i)); cyc(1'b1);
    end
    repeat (4) cyc(1'b0);
    chk("ovf.flag", 128'(overflow), 128'd1);
    chk("ovf.drop", 128'(drop_count), 128'd3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf.w%0d.valid", i), 128'(bus.axis0_out_tvalid), 128'd1);
      chk($sformatf("ovf.w%0d.data0", i), bus.axis0_out_tdata, pat(100 + 4*i));
      chk($sformatf("ovf.w%0d.data3", i), bus.axis3_out_tdata, pat(103 + 4*i));
      chk($sformatf("ovf.w%0d.last", i), 128'(bus.axis0_out_tlast), 128'd1);
      pop();
    end
    chk("drain2.valid", 128'(bus.axis0_out_tvalid), 128'd0);

    // reset with a queued word and a partial packet open
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(200)); set_seg(1, 1'b0, 1'b0, 4'd0, 1'b0, pat(201)); cyc(1'b1);
    set_seg(0, 1'b0, 1'b0, 4'd0, 1'b0, pat(202)); set_seg(1, 1'b0, 1'b1, 4'd0, 1'b0, pat(203)); cyc(1'b1);
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(204)); set_seg(1, 1'b0, 1'b0, 4'd0, 1'b0, pat(205)); cyc(1'b1);
    reset = 1'b1;
    #2;
    chk("mrst.valid", 128'(bus.axis0_out_tvalid), 128'd0);
    chk("mrst.data0", bus.axis0_out_tdata, 128'd0);
    chk("mrst.last", 128'(bus.axis0_out_tlast), 128'd0);
    chk("mrst.ovf", 128'(overflow), 128'd0);
    chk("mrst.drop", 128'(drop_count), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_seg(0, 1'b0, 1'b1, 4'd0, 1'b0, pat(206)); cyc(1'b1);
    set_seg(0, 1'b1, 1'b0, 4'd0, 1'b0, pat(210)); set_seg(1, 1'b0, 1'b1, 4'd4, 1'b0, pat(211)); cyc(1'b1);
    repeat (3) cyc(1'b0);
    check_word("post", pat(210), pat(211), 128'd0, 128'd0, 6'h00, 6'h04, 6'h10, 6'h10, 1'b1);
    pop();
    chk("post.drain", 128'(bus.axis0_out_tvalid), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
